// File: rtl/sia_wbq_pkg.sv
// Shared constants for the SIA Wishbone queue front end: register addresses,
// STATUS bit positions, CONFIG field offsets and interrupt source indices.
package sia_wbq_pkg;

    localparam int SIA_DW = 16;

    localparam logic [2:0] SIA_ADR_TRXDAT  = 3'd0;
    localparam logic [2:0] SIA_ADR_STATUS  = 3'd1;
    localparam logic [2:0] SIA_ADR_INTENA  = 3'd2;
    localparam logic [2:0] SIA_ADR_INTPND  = 3'd3;
    localparam logic [2:0] SIA_ADR_CONFIG  = 3'd4;
    localparam logic [2:0] SIA_ADR_BITRATL = 3'd5;
    localparam logic [2:0] SIA_ADR_BITRATH = 3'd6;
    localparam logic [2:0] SIA_ADR_WMARK   = 3'd7;

    localparam int SIA_ST_RXNE = 15;
    localparam int SIA_ST_RXF  = 14;
    localparam int SIA_ST_OVR  = 13;
    localparam int SIA_ST_TXWM = 3;
    localparam int SIA_ST_TXE  = 2;
    localparam int SIA_ST_RXWM = 1;
    localparam int SIA_ST_TXNF = 0;

    localparam int SIA_CFG_BITS   = 0;
    localparam int SIA_CFG_EEDD   = 8;
    localparam int SIA_CFG_EEDC   = 9;
    localparam int SIA_CFG_TXCMOD = 10;
    localparam int SIA_CFG_RXCPOL = 13;

    localparam int SIA_IRQ_RXWM = 0;
    localparam int SIA_IRQ_TXWM = 1;
    localparam int SIA_IRQ_OVR  = 2;
    localparam int SIA_IRQ_TXE  = 3;

endpackage

// File: rtl/sia_wbq_if.sv
// Wishbone B.4 pipelined bus bundle between the CPU master and the SIA slave.
interface sia_wbq_if;
    import sia_wbq_pkg::*;

    logic [2:0]        adr_i;
    logic              we_i;
    logic              cyc_i;
    logic              stb_i;
    logic [SIA_DW-1:0] dat_i;
    logic [1:0]        sel_i;
    logic [SIA_DW-1:0] dat_o;
    logic              ack_o;
    logic              stall_o;

    modport master (output adr_i, we_i, cyc_i, stb_i, dat_i, sel_i,
                    input  dat_o, ack_o, stall_o);
    modport slave  (input  adr_i, we_i, cyc_i, stb_i, dat_i, sel_i,
                    output dat_o, ack_o, stall_o);

endinterface

// File: rtl/sia_fifo.sv
// Word queue with level counter; a push and pop in the same cycle both
// succeed even when full or empty, leaving the level unchanged.
module sia_fifo
    import sia_wbq_pkg::*;
#(
    parameter int LOG2 = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [SIA_DW-1:0] dat_i,
    output logic [SIA_DW-1:0] dat_o,
    output logic [LOG2:0]     level_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int DEPTH = 1 << LOG2;

    logic [SIA_DW-1:0] mem [DEPTH];
    logic [LOG2-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LOG2:0]     level_q, level_d;
    logic              do_push, do_pop;

    assign full_o  = (level_q == (LOG2+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    // Empty queue presents zero so the head never shows stale or unwritten storage.
    assign dat_o   = empty_o ? '0 : mem[rptr_q];

    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & (~empty_o | push_i);

    always_comb begin
        wptr_d  = wptr_q + LOG2'(do_push);
        rptr_d  = rptr_q + LOG2'(do_pop);
        level_d = level_q + (LOG2+1)'(do_push) - (LOG2+1)'(do_pop);
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr_q] <= dat_i;
    end

endmodule

// File: rtl/sia_wbq.sv
// SIA Wishbone slave: register file, RX/TX word queues, byte-lane write
// assembly and watermark/overrun interrupt generation.
module sia_wbq
    import sia_wbq_pkg::*;
#(
    parameter int          RXQ_LOG2     = 4,
    parameter int          TXQ_LOG2     = 4,
    parameter logic [19:0] BITRAT_RESET = 20'd83332
) (
    input  logic              clk_i,
    input  logic              reset_i,
    sia_wbq_if.slave          wb,
    output logic [4:0]        bits_o,
    output logic              eedc_o,
    output logic              eedd_o,
    output logic              rxcpol_o,
    output logic [2:0]        txcmod_o,
    output logic [19:0]       bitrat_o,
    input  logic [SIA_DW-1:0] rx_dat_i,
    input  logic              rx_we_i,
    output logic [SIA_DW-1:0] tx_dat_o,
    input  logic              tx_pop_i,
    output logic              tx_not_empty_o,
    output logic              irq_o
);

    logic [4:0]  bits_q;
    logic        eedc_q, eedd_q, rxcpol_q, ovr_q, ack_q, irq_q;
    logic [2:0]  txcmod_q;
    logic [19:0] bitrat_q;
    logic [3:0]  intena_q;
    logic [7:0]  rxwm_q, txwm_q, hold_q;
    logic [SIA_DW-1:0] dat_q, rdata, status, tx_wdat, rx_head;

    logic [RXQ_LOG2:0] rx_level;
    logic [TXQ_LOG2:0] tx_level;
    logic rx_full, rx_empty, tx_full, tx_empty;
    logic accept, wr, rx_pop, tx_push, ovr_set, ovr_clr, rxwm_met, txwm_met;
    logic [3:0] src;

    // Handshake: a beat is taken when cyc & stb & ~stall; ack follows exactly
    // one cycle later. Only a TX-pushing TRXDAT write into a full, non-draining
    // queue stalls.
    assign wb.stall_o = wb.cyc_i & wb.stb_i & wb.we_i & (wb.adr_i == SIA_ADR_TRXDAT)
                      & wb.sel_i[1] & tx_full & ~tx_pop_i;
    assign accept  = wb.cyc_i & wb.stb_i & ~wb.stall_o;
    assign wr      = accept & wb.we_i;
    assign rx_pop  = accept & ~wb.we_i & (wb.adr_i == SIA_ADR_TRXDAT) & ~rx_empty;
    assign tx_push = wr & (wb.adr_i == SIA_ADR_TRXDAT) & wb.sel_i[1];
    assign tx_wdat = {wb.dat_i[15:8], wb.sel_i[0] ? wb.dat_i[7:0] : hold_q};
    assign ovr_set = rx_we_i & rx_full & ~rx_pop;
    assign ovr_clr = wr & (wb.adr_i == SIA_ADR_INTPND) & wb.sel_i[0] & wb.dat_i[SIA_IRQ_OVR];

    sia_fifo #(.LOG2(RXQ_LOG2)) u_rxq (
        .clk_i(clk_i), .reset_i(reset_i), .push_i(rx_we_i), .pop_i(rx_pop),
        .dat_i(rx_dat_i), .dat_o(rx_head), .level_o(rx_level),
        .full_o(rx_full), .empty_o(rx_empty)
    );

    sia_fifo #(.LOG2(TXQ_LOG2)) u_txq (
        .clk_i(clk_i), .reset_i(reset_i), .push_i(tx_push), .pop_i(tx_pop_i),
        .dat_i(tx_wdat), .dat_o(tx_dat_o), .level_o(tx_level),
        .full_o(tx_full), .empty_o(tx_empty)
    );

    assign rxwm_met = 16'(rx_level) >= 16'(rxwm_q);
    assign txwm_met = 16'(tx_level) <= 16'(txwm_q);
    assign src      = {tx_empty, ovr_q, txwm_met, rxwm_met};

    always_comb begin
        status = '0;
        status[SIA_ST_RXNE] = ~rx_empty;
        status[SIA_ST_RXF]  = rx_full;
        status[SIA_ST_OVR]  = ovr_q;
        status[SIA_ST_TXWM] = txwm_met;
        status[SIA_ST_TXE]  = tx_empty;
        status[SIA_ST_RXWM] = rxwm_met;
        status[SIA_ST_TXNF] = ~tx_full;
    end

    always_comb begin
        rdata = '0;
        case (wb.adr_i)
            SIA_ADR_TRXDAT:  rdata = rx_head;
            SIA_ADR_STATUS:  rdata = status;
            SIA_ADR_INTENA:  rdata = {12'd0, intena_q};
            SIA_ADR_INTPND:  rdata = {12'd0, src};
            SIA_ADR_CONFIG:  rdata = {2'b00, rxcpol_q, txcmod_q, eedc_q, eedd_q, 3'b000, bits_q};
            SIA_ADR_BITRATL: rdata = bitrat_q[15:0];
            SIA_ADR_BITRATH: rdata = {12'd0, bitrat_q[19:16]};
            default:         rdata = {txwm_q, rxwm_q};
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            bits_q   <= 5'd10;
            eedc_q   <= 1'b1;
            eedd_q   <= 1'b1;
            txcmod_q <= 3'b100;
            rxcpol_q <= 1'b0;
            bitrat_q <= BITRAT_RESET;
            intena_q <= '0;
            rxwm_q   <= '0;
            txwm_q   <= '0;
            hold_q   <= '0;
            ovr_q    <= 1'b0;
            ack_q    <= 1'b0;
            dat_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            ack_q <= accept;
            dat_q <= (accept & ~wb.we_i) ? rdata : '0;
            irq_q <= |(intena_q & src);
            // A same-cycle overrun outranks the software clear.
            ovr_q <= ovr_set | (ovr_q & ~ovr_clr);
            if (wr) begin
                case (wb.adr_i)
                    SIA_ADR_TRXDAT:
                        if (wb.sel_i == 2'b01) hold_q <= wb.dat_i[7:0];
                    SIA_ADR_INTENA:
                        if (wb.sel_i[0]) intena_q <= wb.dat_i[3:0];
                    SIA_ADR_CONFIG: begin
                        if (wb.sel_i[0]) bits_q <= wb.dat_i[SIA_CFG_BITS +: 5];
                        if (wb.sel_i[1]) begin
                            eedd_q   <= wb.dat_i[SIA_CFG_EEDD];
                            eedc_q   <= wb.dat_i[SIA_CFG_EEDC];
                            txcmod_q <= wb.dat_i[SIA_CFG_TXCMOD +: 3];
                            rxcpol_q <= wb.dat_i[SIA_CFG_RXCPOL];
                        end
                    end
                    SIA_ADR_BITRATL: begin
                        if (wb.sel_i[0]) bitrat_q[7:0]  <= wb.dat_i[7:0];
                        if (wb.sel_i[1]) bitrat_q[15:8] <= wb.dat_i[15:8];
                    end
                    SIA_ADR_BITRATH:
                        if (wb.sel_i[0]) bitrat_q[19:16] <= wb.dat_i[3:0];
                    SIA_ADR_WMARK: begin
                        if (wb.sel_i[0]) rxwm_q <= wb.dat_i[7:0];
                        if (wb.sel_i[1]) txwm_q <= wb.dat_i[15:8];
                    end
                    default: ;
                endcase
            end
        end
    end

    assign wb.ack_o       = ack_q;
    assign wb.dat_o       = dat_q;
    assign irq_o          = irq_q;
    assign tx_not_empty_o = ~tx_empty;
    assign bits_o         = bits_q;
    assign eedc_o         = eedc_q;
    assign eedd_o         = eedd_q;
    assign rxcpol_o       = rxcpol_q;
    assign txcmod_o       = txcmod_q;
    assign bitrat_o       = bitrat_q;

endmodule

// File: tb/tb_sia_wbq.sv
// Directed bench for sia_wbq: register access, queue paths, stall and interrupts.
module tb_sia_wbq;
    import sia_wbq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] rx_dat;
    logic        rx_we, tx_pop;
    logic [4:0]  bits;
    logic        eedc, eedd, rxcpol, tx_not_empty, irq;
    logic [2:0]  txcmod;
    logic [19:0] bitrat;
    logic [15:0] tx_dat;
    logic [15:0] rd;
    int          checks = 0;
    int          failures = 0;

    sia_wbq_if bus();

    sia_wbq dut (
        .clk_i(clk), .reset_i(rst_n), .wb(bus),
        .bits_o(bits), .eedc_o(eedc), .eedd_o(eedd), .rxcpol_o(rxcpol),
        .txcmod_o(txcmod), .bitrat_o(bitrat),
        .rx_dat_i(rx_dat), .rx_we_i(rx_we),
        .tx_dat_o(tx_dat), .tx_pop_i(tx_pop), .tx_not_empty_o(tx_not_empty),
        .irq_o(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
        bus.adr_i = '0;   bus.dat_i = '0;   bus.sel_i = '0;
    endtask

    // One single-beat transfer; returns at the falling edge where ack should be high.
    task automatic wb_cycle(input logic [2:0] adr, input logic we, input logic [15:0] wdat,
                            input logic [1:0] sel, output logic [15:0] rdat);
        int n;
        @(negedge clk);
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = we;
        bus.adr_i = adr;  bus.dat_i = wdat; bus.sel_i = sel;
        #1;
        n = 0;
        while (bus.stall_o && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 50) chk("stall_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        bus_idle();
        @(negedge clk);
        chk("ack", 32'(bus.ack_o), 32'd1);
        rdat = bus.dat_o;
    endtask

    task automatic wb_wr(input logic [2:0] adr, input logic [15:0] wdat, input logic [1:0] sel);
        logic [15:0] dummy;
        wb_cycle(adr, 1'b1, wdat, sel, dummy);
    endtask

    task automatic wb_rd_chk(input string tag, input logic [2:0] adr, input logic [15:0] exp);
        logic [15:0] r;
        wb_cycle(adr, 1'b0, 16'h0, 2'b11, r);
        chk(tag, 32'(r), 32'(exp));
    endtask

    initial begin
        bus_idle();
        rx_dat = '0; rx_we = 1'b0; tx_pop = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_bits", 32'(bits), 32'd10);
        chk("rst_txcmod", 32'(txcmod), 32'd4);
        chk("rst_bitrat", 32'(bitrat), 32'd83332);
        chk("rst_eedc", 32'(eedc), 32'd1);
        chk("rst_eedd", 32'(eedd), 32'd1);
        chk("rst_rxcpol", 32'(rxcpol), 32'd0);
        chk("rst_ack", 32'(bus.ack_o), 32'd0);
        chk("rst_stall", 32'(bus.stall_o), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_dat_o", 32'(bus.dat_o), 32'd0);
        chk("rst_tx_dat", 32'(tx_dat), 32'd0);
        chk("rst_tx_ne", 32'(tx_not_empty), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        wb_rd_chk("cfg_rst_rd", SIA_ADR_CONFIG, 16'h130A);
        wb_wr(SIA_ADR_CONFIG, 16'h3F0F, 2'b11);
        chk("cfg_bits", 32'(bits), 32'd15);
        chk("cfg_txcmod", 32'(txcmod), 32'd7);
        chk("cfg_rxcpol", 32'(rxcpol), 32'd1);
        wb_rd_chk("cfg_rd", SIA_ADR_CONFIG, 16'h3F0F);
        wb_rd_chk("status_idle", SIA_ADR_STATUS, 16'h000F);

        // RX single word, then read of an empty queue
        @(negedge clk) begin rx_we = 1'b1; rx_dat = 16'hABCD; end
        @(negedge clk) rx_we = 1'b0;
        wb_rd_chk("rx_rd", SIA_ADR_TRXDAT, 16'hABCD);
        wb_rd_chk("rx_rd_empty", SIA_ADR_TRXDAT, 16'h0000);
        wb_rd_chk("status_rx_empty", SIA_ADR_STATUS, 16'h000F);

        // Byte-lane assembly: low byte held, high-byte write pushes
        wb_wr(SIA_ADR_TRXDAT, 16'h00EF, 2'b01);
        chk("hold_no_push", 32'(tx_not_empty), 32'd0);
        wb_wr(SIA_ADR_TRXDAT, 16'hBE00, 2'b10);
        chk("tx_head", 32'(tx_dat), 32'hBEEF);
        chk("tx_ne", 32'(tx_not_empty), 32'd1);
        wb_rd_chk("status_tx1", SIA_ADR_STATUS, 16'h0003);

        // Fill TX to 16 then stall until the transmitter pops
        for (int i = 1; i <= 15; i++) wb_wr(SIA_ADR_TRXDAT, 16'h1000 + 16'(i), 2'b11);
        wb_rd_chk("status_tx_full", SIA_ADR_STATUS, 16'h0002);
        @(negedge clk);
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b1;
        bus.adr_i = SIA_ADR_TRXDAT; bus.dat_i = 16'h5555; bus.sel_i = 2'b11;
        #1 chk("stall_set", 32'(bus.stall_o), 32'd1);
        repeat (3) @(negedge clk);
        #1;
        chk("stall_hold", 32'(bus.stall_o), 32'd1);
        chk("stall_no_ack", 32'(bus.ack_o), 32'd0);
        tx_pop = 1'b1;
        #1 chk("stall_release", 32'(bus.stall_o), 32'd0);
        @(posedge clk); #1;
        tx_pop = 1'b0;
        bus_idle();
        @(negedge clk);
        chk("stall_ack", 32'(bus.ack_o), 32'd1);
        chk("stall_new_head", 32'(tx_dat), 32'h1001);
        @(negedge clk);
        chk("stall_single_ack", 32'(bus.ack_o), 32'd0);
        wb_rd_chk("status_still_full", SIA_ADR_STATUS, 16'h0002);

        // Overflow RX with 17 pushes, then interrupt enable and clear
        for (int i = 0; i < 17; i++) begin
            @(negedge clk) begin rx_we = 1'b1; rx_dat = 16'h2000 + 16'(i); end
        end
        @(negedge clk) rx_we = 1'b0;
        wb_rd_chk("status_ovr", SIA_ADR_STATUS, 16'hE002);
        wb_rd_chk("intpnd_ovr", SIA_ADR_INTPND, 16'h0005);
        wb_wr(SIA_ADR_INTENA, 16'h0004, 2'b01);
        chk("irq_lag", 32'(irq), 32'd0);
        @(negedge clk);
        chk("irq_set", 32'(irq), 32'd1);
        wb_wr(SIA_ADR_INTPND, 16'h0004, 2'b01);
        chk("irq_pre_clear", 32'(irq), 32'd1);
        @(negedge clk);
        chk("irq_clear", 32'(irq), 32'd0);
        wb_rd_chk("status_ovr_clr", SIA_ADR_STATUS, 16'hC002);

        // Read and push on a full RX queue in the same cycle
        @(negedge clk);
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b0;
        bus.adr_i = SIA_ADR_TRXDAT; bus.sel_i = 2'b11;
        rx_we = 1'b1; rx_dat = 16'h3333;
        @(posedge clk); #1;
        bus_idle();
        rx_we = 1'b0;
        @(negedge clk);
        chk("simul_ack", 32'(bus.ack_o), 32'd1);
        chk("simul_dat", 32'(bus.dat_o), 32'h2000);
        wb_rd_chk("status_simul", SIA_ADR_STATUS, 16'hC002);
        chk("simul_irq", 32'(irq), 32'd0);
        for (int i = 1; i <= 15; i++) wb_rd_chk("rx_drain", SIA_ADR_TRXDAT, 16'h2000 + 16'(i));
        wb_rd_chk("rx_last", SIA_ADR_TRXDAT, 16'h3333);
        wb_rd_chk("status_rx_done", SIA_ADR_STATUS, 16'h0002);

        // Drain TX through the transmitter side
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            #1 chk("tx_drain", 32'(tx_dat), 32'h1000 + 32'(i));
            tx_pop = 1'b1;
            @(negedge clk) tx_pop = 1'b0;
        end
        #1 chk("tx_last", 32'(tx_dat), 32'h5555);
        @(negedge clk) tx_pop = 1'b1;
        @(negedge clk) tx_pop = 1'b0;
        #1;
        chk("tx_empty_ne", 32'(tx_not_empty), 32'd0);
        chk("tx_empty_dat", 32'(tx_dat), 32'd0);

        // Reset during an in-flight ack
        @(negedge clk);
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b0;
        bus.adr_i = SIA_ADR_CONFIG; bus.sel_i = 2'b11;
        @(posedge clk); #1;
        chk("mid_ack", 32'(bus.ack_o), 32'd1);
        bus_idle();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ack", 32'(bus.ack_o), 32'd0);
        chk("mid_rst_bits", 32'(bits), 32'd10);
        chk("mid_rst_txcmod", 32'(txcmod), 32'd4);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
